// File: rtl/regfile_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_queue_if
// Brief   : Bus bundle for the register-file writeback queue. It carries the
//           producer handshake, the register-file write port, the two
//           forwarding lookups and the occupancy status.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rf_port_busy;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_address;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] lookup_addr_1;
  logic [ADDR_W-1:0] lookup_addr_2;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic [CNT_W-1:0]  count;
  logic              empty;

  // Producer / register-file / reader side
  modport master (
    output wb_valid, wb_addr, wb_data, rf_port_busy, lookup_addr_1, lookup_addr_2,
    input  wb_ready, rf_write_enable, rf_write_address, rf_write_data,
    input  fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count, empty
  );

  // Queue side
  modport slave (
    input  wb_valid, wb_addr, wb_data, rf_port_busy, lookup_addr_1, lookup_addr_2,
    output wb_ready, rf_write_enable, rf_write_address, rf_write_data,
    output fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count, empty
  );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_queue
// Brief   : Small FIFO of pending register writebacks draining one write per
//           cycle into the register file through a registered output stage,
//           with youngest-first forwarding for two read addresses.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input wire clock,
  input wire Reset,
  regfile_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Ready depends on occupancy only; writes to register 0 handshake but are dropped
  assign w_ready = (r_count != c_full_cnt);
  assign w_push  = bus.wb_valid & w_ready & (bus.wb_addr != '0);
  assign w_pop   = (r_count != '0) & ~bus.rf_port_busy;

  // Entry storage: written at the write pointer on an accepted push
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_wptr] <= bus.wb_addr;
      r_data[r_wptr] <= bus.wb_data;
    end
  end

  // Pointers, occupancy and the registered output stage
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_waddr <= r_addr[r_rptr];
        r_wdata <= r_data[r_rptr];
      end
      r_we    <= w_pop;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  logic [ADDR_W-1:0] w_lk_addr [2];
  assign w_lk_addr[0] = bus.lookup_addr_1;
  assign w_lk_addr[1] = bus.lookup_addr_2;

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic              w_hit;
    logic [DATA_W-1:0] w_val;
    logic [PTR_W-1:0]  w_idx;

    // Scan oldest-to-youngest so the youngest matching entry wins; the
    // output stage is the oldest candidate and is considered first
    always_comb begin
      w_hit = 1'b0;
      w_val = '0;
      w_idx = '0;
      if (r_we && (r_waddr == w_lk_addr[p])) begin
        w_hit = 1'b1;
        w_val = r_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = r_rptr + PTR_W'(k);
        if ((CNT_W'(k) < r_count) && (r_addr[w_idx] == w_lk_addr[p])) begin
          w_hit = 1'b1;
          w_val = r_data[w_idx];
        end
      end
      if (w_lk_addr[p] == '0) begin
        w_hit = 1'b0;
        w_val = '0;
      end
    end
  end

  assign bus.wb_ready         = w_ready;
  assign bus.rf_write_enable  = r_we;
  assign bus.rf_write_address = r_waddr;
  assign bus.rf_write_data    = r_wdata;
  assign bus.fwd_hit_1        = g_fwd[0].w_hit;
  assign bus.fwd_data_1       = g_fwd[0].w_val;
  assign bus.fwd_hit_2        = g_fwd[1].w_hit;
  assign bus.fwd_data_2       = g_fwd[1].w_val;
  assign bus.count            = r_count;
  assign bus.empty            = (r_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writeback_queue
// Brief   : Self-checking bench for regfile_writeback_queue. A queue-level
//           reference model predicts status and forwarding; a scoreboard of
//           accepted writes is consumed by an independent write monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clock;
  logic Reset;

  regfile_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_en  = 1'b0;
  bit   done    = 1'b0;

  // Reference model: pending writes in acceptance order, plus the write in flight
  ent_t pend  [$];
  ent_t exp_q [$];
  ent_t m_out;
  bit   m_out_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void mfwd(input logic [ADDR_W-1:0] la, output bit hit,
                               output logic [DATA_W-1:0] dat);
    hit = 1'b0;
    dat = '0;
    if (la == '0) return;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].a == la) begin
        hit = 1'b1;
        dat = pend[i].d;
        return;
      end
    end
    if (m_out_v && m_out.a == la) begin
      hit = 1'b1;
      dat = m_out.d;
    end
  endfunction

  task automatic check_state();
    bit                h1, h2;
    logic [DATA_W-1:0] d1, d2;
    mfwd(bus.lookup_addr_1, h1, d1);
    mfwd(bus.lookup_addr_2, h2, d2);
    chk("wb_ready", 64'(bus.wb_ready), 64'(pend.size() != DEPTH));
    chk("count",    64'(bus.count),    64'(pend.size()));
    chk("empty",    64'(bus.empty),    64'(pend.size() == 0));
    chk("rf_we",    64'(bus.rf_write_enable),  64'(m_out_v));
    chk("rf_addr",  64'(bus.rf_write_address), 64'(m_out.a));
    chk("rf_data",  64'(bus.rf_write_data),    64'(m_out.d));
    chk("fwd_hit_1",  64'(bus.fwd_hit_1),  64'(h1));
    chk("fwd_data_1", 64'(bus.fwd_data_1), 64'(d1));
    chk("fwd_hit_2",  64'(bus.fwd_hit_2),  64'(h2));
    chk("fwd_data_2", 64'(bus.fwd_data_2), 64'(d2));
  endtask

  // One clock: drive at negedge, check current state, then advance model at posedge
  task automatic cycle(input bit rst, input bit v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit busy,
                       input logic [ADDR_W-1:0] l1, input logic [ADDR_W-1:0] l2);
    bit full;
    @(negedge clock);
    Reset             = rst;
    bus.wb_valid      = v;
    bus.wb_addr       = a;
    bus.wb_data       = d;
    bus.rf_port_busy  = busy;
    bus.lookup_addr_1 = l1;
    bus.lookup_addr_2 = l2;
    #1;
    if (chk_en) check_state();
    @(posedge clock);
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_out   = '{a: '0, d: '0};
      m_out_v = 1'b0;
    end else begin
      full = (pend.size() == DEPTH);
      if (pend.size() > 0 && !busy) begin
        m_out   = pend.pop_front();
        m_out_v = 1'b1;
      end else begin
        m_out_v = 1'b0;
      end
      if (v && !full && a != '0) begin
        pend.push_back('{a: a, d: d});
        exp_q.push_back('{a: a, d: d});
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic idle(input bit busy, input logic [ADDR_W-1:0] l1, input logic [ADDR_W-1:0] l2);
    cycle(1'b0, 1'b0, '0, '0, busy, l1, l2);
  endtask

  // Write monitor: every register-file write must be the oldest accepted writeback
  initial begin
    ent_t e;
    while (!done) begin
      @(negedge clock);
      if (chk_en && bus.rf_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'(bus.rf_write_address), 64'h0);
          chk("wr_unexpected_flag", 64'h1, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_order_addr", 64'(bus.rf_write_address), 64'(e.a));
          chk("wr_order_data", 64'(bus.rf_write_data),    64'(e.d));
        end
      end
    end
  end

  initial begin
    int guard;
    Reset = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rf_port_busy = 1'b0; bus.lookup_addr_1 = '0; bus.lookup_addr_2 = '0;
    m_out = '{a: '0, d: '0};
    m_out_v = 1'b0;

    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    // Single write with fixed latency
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    idle(1'b0, 5'd5, 5'd0);
    #1;
    chk("t1_we",   64'(bus.rf_write_enable),  64'h1);
    chk("t1_addr", 64'(bus.rf_write_address), 64'h5);
    chk("t1_data", 64'(bus.rf_write_data),    64'hDEADBEEF);
    idle(1'b0, 5'd0, 5'd0);
    #1;
    chk("t1_we_off", 64'(bus.rf_write_enable), 64'h0);
    chk("t1_count",  64'(bus.count),           64'h0);

    // Write to register 0 is accepted and dropped
    cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
    #1;
    chk("t2_count", 64'(bus.count),     64'h0);
    chk("t2_ready", 64'(bus.wb_ready),  64'h1);
    chk("t2_hit1",  64'(bus.fwd_hit_1), 64'h0);
    idle(1'b0, 5'd0, 5'd0);
    idle(1'b0, 5'd0, 5'd0);

    // Fill while busy, overflow push ignored, then drain in order
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b1, 5'(i), 32'(i * 'h11), 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd4);
    #1;
    chk("t3_count", 64'(bus.count),    64'h4);
    chk("t3_ready", 64'(bus.wb_ready), 64'h0);
    for (int i = 0; i < 6; i++) idle(1'b0, 5'd9, 5'd4);

    // Forwarding returns the youngest pending value
    cycle(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd7, 32'h2, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd8, 32'h3, 1'b1, 5'd0, 5'd0);
    idle(1'b1, 5'd7, 5'd8);
    #1;
    chk("t4_hit1",  64'(bus.fwd_hit_1),  64'h1);
    chk("t4_data1", 64'(bus.fwd_data_1), 64'h2);
    chk("t4_hit2",  64'(bus.fwd_hit_2),  64'h1);
    chk("t4_data2", 64'(bus.fwd_data_2), 64'h3);
    idle(1'b1, 5'd9, 5'd7);
    for (int i = 0; i < 5; i++) idle(1'b0, 5'd7, 5'd8);

    // Steady state: push and pop every cycle
    cycle(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 5'(12 + i), 32'(32'hB0 + i), 1'b0, 5'(12 + i), 5'd11);
    #1;
    chk("t5_count", 64'(bus.count), 64'h2);
    for (int i = 0; i < 4; i++) idle(1'b0, 5'd0, 5'd0);

    // Reset mid-operation drops everything, including the output stage
    cycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 5'd6);
    #1;
    chk("t6_count", 64'(bus.count),           64'h0);
    chk("t6_empty", 64'(bus.empty),           64'h1);
    chk("t6_we",    64'(bus.rf_write_enable), 64'h0);
    chk("t6_hit1",  64'(bus.fwd_hit_1),       64'h0);
    chk("t6_hit2",  64'(bus.fwd_hit_2),       64'h0);
    for (int i = 0; i < 4; i++) idle(1'b0, 5'd4, 5'd6);

    // Randomized traffic with small address range to exercise forwarding
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Bounded drain
    guard = 0;
    while ((pend.size() != 0 || m_out_v) && guard < 20) begin
      idle(1'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      guard++;
    end
    idle(1'b0, 5'd0, 5'd0);
    idle(1'b0, 5'd0, 5'd0);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'h0);
    chk("drain_count",      64'(bus.count),    64'h0);

    done = 1'b1;
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
